mux_arb32: RTL

Two-requester arbiter and output register for the shared 32-bit 2:1 operand mux. Requesters A and B each present a 32-bit word with a valid-style request. The block picks one, drives the mux select, and captures the chosen word into a registered output with a valid/ready handshake. It is the sequencing front end that lets two producers share one 32-bit result path without collisions.

---
 rtl/mux_arb32.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_arb32.sv
// mux_arb32: two-requester arbiter and registered output for a shared 32-bit 2:1 operand mux.
//
// Requesters A and B present a word with a level request. When the output register can accept
// (empty, or being consumed this cycle), one requester gets a combinational grant. Its word is
// captured into a registered result with a valid/ready handshake, and the mux select is updated
// to match. Consumption and a new capture can happen on the same edge, so the block sustains
// one word per cycle.
//
// Build option:
//   MUX_ARB_RR_EN  defined   -> round-robin on ties (the requester other than last_src wins)
//                  undefined -> fixed priority on ties (A always wins)
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   req_a/data_a/gnt_a requester A request, word, and accept strobe
//   req_b/data_b/gnt_b requester B request, word, and accept strobe
//   sel                registered mux select (0=A, 1=B)
//   result, result_src registered selected word and its source
//   result_valid       result holds an unconsumed word
//   result_ready       downstream consumes result when result_valid=1
//   xfer_cnt           wrapping count of words consumed downstream
module mux_arb32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] result,
  output logic             result_src,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             result_src_q, result_src_d;
  logic             sel_q, sel_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  // Source of the most recent grant; resets to B so that A wins the first tie.
  logic             last_src_q, last_src_d;

  logic can_accept;
  logic consume;
  logic tie_to_b;

  assign can_accept = !result_valid_q || result_ready;
  assign consume    = result_valid_q && result_ready;

`ifdef MUX_ARB_RR_EN
  // Round-robin: on a tie, B wins only if A was granted last.
  assign tie_to_b = !last_src_q;
`else
  assign tie_to_b = 1'b0;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (can_accept) begin
      if (req_a && req_b) begin
        gnt_a = !tie_to_b;
        gnt_b = tie_to_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    result_d       = result_q;
    result_src_d   = result_src_q;
    sel_d          = sel_q;
    result_valid_d = result_valid_q;
    last_src_d     = last_src_q;
    xfer_cnt_d     = xfer_cnt_q;

    if (consume) begin
      result_valid_d = 1'b0;
      xfer_cnt_d     = xfer_cnt_q + CNT_W'(1);
    end

    // A grant overrides the clear above, giving back-to-back capture.
    if (gnt_a) begin
      result_d       = data_a;
      result_src_d   = 1'b0;
      sel_d          = 1'b0;
      result_valid_d = 1'b1;
      last_src_d     = 1'b0;
    end else if (gnt_b) begin
      result_d       = data_b;
      result_src_d   = 1'b1;
      sel_d          = 1'b1;
      result_valid_d = 1'b1;
      last_src_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q       <= '0;
      result_src_q   <= 1'b0;
      sel_q          <= 1'b0;
      result_valid_q <= 1'b0;
      last_src_q     <= 1'b1;
      xfer_cnt_q     <= '0;
    end else begin
      result_q       <= result_d;
      result_src_q   <= result_src_d;
      sel_q          <= sel_d;
      result_valid_q <= result_valid_d;
      last_src_q     <= last_src_d;
      xfer_cnt_q     <= xfer_cnt_d;
    end
  end

  assign result       = result_q;
  assign result_src   = result_src_q;
  assign sel          = sel_q;
  assign result_valid = result_valid_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule
